dmem_ctrl: RTL
==============

// Module: dmem_ctrl
// PURPOSE
//  Sequences data-memory accesses for the ME stage: takes one load/store per
//  instruction, drives a req/ack handshake to variable-latency data memory,
//  aligns/sign-extends load data for the ME pipeline register's i_mem_read,
//  and holds the pipeline via o_stall until the access finishes.
// PARAMETERS
//  ADDR_W   32   byte-address width
//  WORD_W   32   data width (fixed 32: four byte lanes)
//  TIMEOUT  255  max cycles waiting for m_ack before abort (1..255)
// PORTS
//  clk        in   1       clock, rising edge
//  clr        in   1       reset, asynchronous, active-high
//  i_mem_op   in   2       0 none, 1 load, 2 store, 3 none
//  i_size     in   2       0 byte, 1 half, 2/3 word
//  i_sign     in   1       loads: 1 sign-extend, 0 zero-extend
//  i_addr     in   ADDR_W  byte address
//  i_wdata    in   WORD_W  store data, low-aligned
//  o_stall    out  1       hold upstream stages and ME input
//  o_rdata    out  WORD_W  aligned, extended load data
//  o_fault    out  1       1-cycle pulse: misaligned access or timeout
//  m_req      out  1       memory request, held until m_ack
//  m_we       out  1       1 write, 0 read
//  m_addr     out  ADDR_W  word address: i_addr with [1:0] forced to 0
//  m_wdata    out  WORD_W  store data replicated across lanes
//  m_be       out  4       byte enables
//  m_ack      in   1       memory done; m_rdata valid in the same cycle
//  m_rdata    in   WORD_W  raw read word
// BEHAVIOUR
//  - Reset (async): state IDLE; m_req, m_we, m_be, o_fault, wait counter and
//    o_rdata = 0. o_stall follows the IDLE rule below.
//  - FSM states: IDLE, REQ, DONE.
//  - IDLE: valid op (1/2) and aligned -> o_stall=1 (combinational). Latch
//    addr/we/be/wdata/size/sign. Next state REQ.
//    Misaligned op (half with addr[0]=1, word with addr[1:0]!=0) -> no
//    request; o_fault=1 next cycle; o_stall=0; o_rdata=0; stay IDLE.
//  - REQ: m_req=1 and all m_* outputs stable. o_stall=1. Counter increments
//    each cycle.
//    m_ack=1 -> capture the aligned/extended word into o_rdata; go to DONE.
//    Counter reaches TIMEOUT with no ack -> drop m_req; o_rdata=0;
//    o_fault=1 in DONE; go to DONE.
//  - DONE: o_stall=0 for exactly one cycle, so the pipeline advances on this
//    edge. Always go to IDLE. The same op is never reissued.
//  - o_rdata holds its value until the next load completes. Stores and
//    timeouts write 0.
//  - Latency: an aligned access with ack on the k-th REQ cycle stalls k+1
//    cycles, counting the IDLE cycle.
//  - m_be: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1];
//    word = 1111.
//  - Load data: byte lane addr[1:0], half lane addr[1]. Shift to [7:0] or
//    [15:0], then extend per the latched sign.
//  - m_ack outside REQ is ignored.
//  - clr mid-REQ: m_req drops immediately (async); memory must tolerate an
//    abandoned request.
// TESTING
//  - Word load at 0x100, m_ack on the 3rd REQ cycle, m_rdata=0xDEADBEEF ->
//    o_stall high 4 cycles; o_rdata=0xDEADBEEF; m_be=1111.
//  - Signed byte load at 0x103, m_rdata=0x80xxxxxx -> o_rdata=0xFFFFFF80.
//    Same access with i_sign=0 -> o_rdata=0x00000080.
//  - Half store at 0x102, i_wdata=0x1234 -> m_we=1; m_be=1100;
//    m_wdata=0x12341234; m_addr=0x100.
//  - Word load at 0x101 -> no m_req; o_fault pulses once; o_stall never high.
//  - Store, m_ack never asserted, TIMEOUT=4 -> m_req high 4 cycles, then
//    o_fault pulse; o_stall drops in DONE.
//  - Assert clr in REQ cycle 2 -> m_req=0 asynchronously; state IDLE;
//    back-to-back loads then issue cleanly.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory access sequencer for the ME stage.
// Accepts one load or store per instruction, runs a req/ack handshake with a
// variable-latency memory, then aligns and extends the returned load data.
// o_stall holds the pipeline from the accepting IDLE cycle through the last
// REQ cycle. It drops for the single DONE cycle, which is when the pipeline
// advances. Misaligned accesses never reach memory; they raise a one-cycle
// fault instead. A request that waits TIMEOUT cycles for m_ack is abandoned.
module dmem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [1:0]        i_mem_op,
    input  logic [1:0]        i_size,
    input  logic              i_sign,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic              o_stall,
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_fault,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [WORD_W-1:0] m_wdata,
    output logic [3:0]        m_be,
    input  logic              m_ack,
    input  logic [WORD_W-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;

    // The last REQ cycle allowed without an ack; the counter is 0 in REQ cycle 1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t              state_reg, state_next;
    logic [7:0]          cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                we_reg;
    logic [3:0]          be_reg;
    logic [WORD_W-1:0]   wdata_reg;
    logic [1:0]          size_reg;
    logic                sign_reg;
    logic [1:0]          lane_reg;
    logic [WORD_W-1:0]   rdata_reg;
    logic                fault_reg;

    // Control strobes produced by the FSM decode
    logic                accept;
    logic                reject;
    logic                ack_evt;
    logic                timeout_evt;

    // Request decode of the incoming instruction
    logic                op_valid;
    logic                misaligned;
    logic [3:0]          be_dec;
    logic [WORD_W-1:0]   wdata_rep;

    // Load-path alignment
    logic [7:0]          rd_byte [4];
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [WORD_W-1:0]   load_word;

    assign op_valid = (i_mem_op == OP_LOAD) || (i_mem_op == OP_STORE);

    // Size codes 2 and 3 are both word accesses, so i_size[1] alone flags a word.
    assign misaligned = ((i_size == SZ_HALF) && i_addr[0]) ||
                        (i_size[1] && (i_addr[1:0] != 2'b00));

    // One byte enable per lane: byte picks its lane, half picks its pair, word picks all.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            always_comb begin
                case (i_size)
                    SZ_BYTE: be_dec[gi] = (i_addr[1:0] == 2'(gi));
                    SZ_HALF: be_dec[gi] = (i_addr[1] == 1'(gi / 2));
                    default: be_dec[gi] = 1'b1;
                endcase
            end
        end
    endgenerate

    // Store data is replicated across lanes so memory only needs the byte enables.
    always_comb begin
        case (i_size)
            SZ_BYTE: wdata_rep = {4{i_wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{i_wdata[15:0]}};
            default: wdata_rep = i_wdata;
        endcase
    end

    // Split the raw read word into byte lanes for lane selection.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = m_rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rd_byte[lane_reg];
    assign half_sel = lane_reg[1] ? m_rdata[31:16] : m_rdata[15:0];

    // Shift the selected lane down to bit 0 and extend according to the latched sign.
    always_comb begin
        case (size_reg)
            SZ_BYTE: load_word = {{24{sign_reg & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_word = {{16{sign_reg & half_sel[15]}}, half_sel};
            default: load_word = m_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; m_req comes straight from the state
    // register, so an asynchronous clear drops it at once.
    always_comb begin
        state_next  = state_reg;
        o_stall     = 1'b0;
        m_req       = 1'b0;
        accept      = 1'b0;
        reject      = 1'b0;
        ack_evt     = 1'b0;
        timeout_evt = 1'b0;
        case (state_reg)
            IDLE: begin
                if (op_valid) begin
                    if (misaligned) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        o_stall    = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                m_req   = 1'b1;
                o_stall = 1'b1;
                if (m_ack) begin
                    ack_evt    = 1'b1;
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    timeout_evt = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Wait counter: runs only while a request is outstanding.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_reg <= 8'd0;
        end else if (state_reg == REQ) begin
            cnt_reg <= cnt_reg + 8'd1;
        end else begin
            cnt_reg <= 8'd0;
        end
    end

    // Latch the accepted request so the m_* outputs stay stable for the whole handshake.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            be_reg    <= 4'b0000;
            wdata_reg <= '0;
            size_reg  <= 2'd0;
            sign_reg  <= 1'b0;
            lane_reg  <= 2'd0;
        end else if (accept) begin
            addr_reg  <= {i_addr[ADDR_W-1:2], 2'b00};
            we_reg    <= (i_mem_op == OP_STORE);
            be_reg    <= be_dec;
            wdata_reg <= wdata_rep;
            size_reg  <= i_size;
            sign_reg  <= i_sign;
            lane_reg  <= i_addr[1:0];
        end
    end

    // Load result: updated by a completed load, cleared by stores, timeouts and rejects.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rdata_reg <= '0;
        end else if (ack_evt) begin
            rdata_reg <= we_reg ? '0 : load_word;
        end else if (timeout_evt || reject) begin
            rdata_reg <= '0;
        end
    end

    // Fault pulse: lands in the cycle after a reject, or in DONE after a timeout.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= reject || timeout_evt;
        end
    end

    assign o_rdata = rdata_reg;
    assign o_fault = fault_reg;
    assign m_we    = we_reg;
    assign m_addr  = addr_reg;
    assign m_wdata = wdata_reg;
    assign m_be    = be_reg;

endmodule
